vga_timing: RTL and testbench



---
 rtl/vga_pkg.sv | 18 +
 rtl/wrap_counter.sv | 15 +
 rtl/vga_timing.sv | 61 ++++++
 tb/tb_vga_timing.sv | 117 +++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared 800x600@60 Hz timing constants and count width for the video pipeline.
package vga_pkg;
  localparam int COUNT_W          = 11;
  localparam int VGA_H_ACTIVE     = 800;
  localparam int VGA_H_FP         = 40;
  localparam int VGA_H_SYNC       = 128;
  localparam int VGA_H_BP         = 88;
  localparam int VGA_V_ACTIVE     = 600;
  localparam int VGA_V_FP         = 1;
  localparam int VGA_V_SYNC       = 4;
  localparam int VGA_V_BP         = 23;
  localparam int VGA_H_TOTAL      = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL      = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
  localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;
endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: enabled up-counter that wraps to 0 after MAX, with combinational terminal count.
module wrap_counter #(
  parameter int WIDTH = 11,
  parameter int MAX   = 1055
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);
  assign wrap = en && (count == WIDTH'(MAX));
  always_ff @(posedge clk)
    count <= rst ? '0 : wrap ? '0 : en ? count + 1'b1 : count;
endmodule

// File: rtl/vga_timing.sv
// vga_timing: raster counters with registered sync/blank flags aligned to the counts.
// Optional frame_start pulse output when VGA_TIMING_FRAME_START_EN is defined.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic               clk,
  input  logic               rst,
  output logic [COUNT_W-1:0] hcount,
  output logic               hsync,
  output logic               hblnk,
  output logic [COUNT_W-1:0] vcount,
  output logic               vsync,
`ifdef VGA_TIMING_FRAME_START_EN
  output logic               frame_start,
`endif
  output logic               vblnk
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [COUNT_W-1:0] HA  = COUNT_W'(H_ACTIVE);
  localparam logic [COUNT_W-1:0] HSS = COUNT_W'(H_ACTIVE + H_FP);
  localparam logic [COUNT_W-1:0] HSE = COUNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COUNT_W-1:0] VA  = COUNT_W'(V_ACTIVE);
  localparam logic [COUNT_W-1:0] VSS = COUNT_W'(V_ACTIVE + V_FP);
  localparam logic [COUNT_W-1:0] VSE = COUNT_W'(V_ACTIVE + V_FP + V_SYNC);
  if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_totals
    $error("vga_timing: H_TOTAL/V_TOTAL must not exceed 2048");
  end
  logic               h_wrap, v_wrap;
  logic [COUNT_W-1:0] hn, vn;
  wrap_counter #(.WIDTH(COUNT_W), .MAX(H_TOTAL - 1)) u_h (
    .clk(clk), .rst(rst), .en(1'b1), .count(hcount), .wrap(h_wrap)
  );
  wrap_counter #(.WIDTH(COUNT_W), .MAX(V_TOTAL - 1)) u_v (
    .clk(clk), .rst(rst), .en(h_wrap), .count(vcount), .wrap(v_wrap)
  );
  // Flags are derived from the counters' next values so they land with the counts.
  always_comb begin
    hn = h_wrap ? '0 : hcount + 1'b1;
    vn = v_wrap ? '0 : vcount + COUNT_W'(h_wrap);
  end
  always_ff @(posedge clk) begin
    hblnk <= !rst && (hn >= HA);
    hsync <= !rst && (hn >= HSS) && (hn < HSE);
    vblnk <= !rst && (vn >= VA);
    vsync <= !rst && (vn >= VSS) && (vn < VSE);
  end
`ifdef VGA_TIMING_FRAME_START_EN
  always_ff @(posedge clk)
    frame_start <= !rst && v_wrap;
`endif
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed checks of vga_timing with default horizontal and shortened vertical timing.
module tb_vga_timing;
  localparam int VA = 6, VF = 1, VS = 2, VB = 3;
  localparam int HT = 1056, VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  logic        clk = 0, rst = 1;
  logic [10:0] hcount, vcount;
  logic        hsync, hblnk, vsync, vblnk;
  int          vectors = 0, errors = 0;
  int          eh = 0, ev = 0;
`ifdef VGA_TIMING_FRAME_START_EN
  logic        frame_start;
  int          fs_count = 0;
  bit          after_rst = 1;
`endif
  always #5 clk = ~clk;
  vga_timing #(.V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) dut (
    .clk(clk), .rst(rst), .hcount(hcount), .hsync(hsync), .hblnk(hblnk),
    .vcount(vcount), .vsync(vsync),
`ifdef VGA_TIMING_FRAME_START_EN
    .frame_start(frame_start),
`endif
    .vblnk(vblnk)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (eh=%0d ev=%0d)", tag, obs, exp, eh, ev);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic adv();
    tick();
    if (eh == HT - 1) begin
      eh = 0;
      ev = (ev == VT - 1) ? 0 : ev + 1;
    end else eh++;
  endtask
  task automatic chk_all(input string tag);
    chk({tag, "_h"}, 32'(hcount), eh);
    chk({tag, "_v"}, 32'(vcount), ev);
    chk({tag, "_hblnk"}, 32'(hblnk), 32'(eh >= 800));
    chk({tag, "_hsync"}, 32'(hsync), 32'(eh >= 840 && eh < 968));
    chk({tag, "_vblnk"}, 32'(vblnk), 32'(ev >= VA));
    chk({tag, "_vsync"}, 32'(vsync), 32'(ev >= VA + VF && ev < VA + VF + VS));
  endtask
  initial begin
    int hs_cnt;
    bit seen;
    rst = 1;
    repeat (3) tick();
    chk_all("por");
    rst = 0;
    repeat (3000) adv();
    chk_all("mid");
    rst = 1;
    repeat (5) tick();
    eh = 0; ev = 0;
    chk_all("rst_mid");
    rst = 0;
    adv();
    chk("rel_h", 32'(hcount), 1);
    chk("rel_v", 32'(vcount), 0);
    repeat (1054) adv();
    chk_all("line_end");
    chk("line_end_h", 32'(hcount), 1055);
    adv();
    chk("wrap_h", 32'(hcount), 0);
    chk("wrap_v", 32'(vcount), 1);
    chk("wrap_hblnk", 32'(hblnk), 0);
    hs_cnt = 0;
    for (int i = 0; i < HT; i++) begin
      adv();
      chk_all("line");
      hs_cnt += int'(hsync);
    end
    chk("hsync_width", hs_cnt, 128);
    for (int i = 0; i < 2 * FRAME; i++) begin
      adv();
      chk_all("frame");
`ifdef VGA_TIMING_FRAME_START_EN
      chk("frame_start", 32'(frame_start), 32'(eh == 0 && ev == 0));
      fs_count += int'(frame_start);
`endif
    end
`ifdef VGA_TIMING_FRAME_START_EN
    chk("fs_count", fs_count, 2);
`endif
    while (!(ev == VA + VF && eh == 900)) adv();
    chk("pre_hsync", 32'(hsync), 1);
    chk("pre_vsync", 32'(vsync), 1);
    rst = 1;
    tick();
    eh = 0; ev = 0;
    chk_all("rst_sync");
`ifdef VGA_TIMING_FRAME_START_EN
    chk("rst_fs", 32'(frame_start), 0);
`endif
    rst = 0;
    seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      adv();
`ifdef VGA_TIMING_FRAME_START_EN
      if (i == 0) chk("rel_fs", 32'(frame_start), 0);
`endif
      seen = hsync;
    end
    chk("hsync_seen", 32'(seen), 1);
    chk("hsync_rise_h", 32'(hcount), 840);
    chk("hsync_rise_v", 32'(vcount), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
